// File: rtl/vedic_mult_pipe.sv
// Pipelined Vedic multiplier: 2x2 gate-level leaves, one register level per recursion step (latency log2(WIDTH)).
// Whole pipe stalls while the output is held; define VEDIC_MULT_SIGNED_EN to add the in_signed two's-complement mode.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef VEDIC_MULT_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);
  localparam int STAGES   = $clog2(WIDTH);
  localparam int LEAVES   = WIDTH / 2;
  // Stage s holds WIDTH^2 / 2^s bits of partial products; all stages packed back to back.
  localparam int TOTAL    = 2*WIDTH*WIDTH - 2*WIDTH;
  localparam int OFF_LAST = TOTAL - 2*WIDTH;

  logic              adv;
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [TOTAL-1:0]  d_raw;
  logic [TOTAL-1:0]  d_all;
  logic [TOTAL-1:0]  q_all;

  assign out_valid = vld[STAGES-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign busy      = |vld;
  assign out_p     = q_all[OFF_LAST +: 2*WIDTH];

  // Leaf level: product of a-chunk i and b-chunk j lives at index i*LEAVES+j.
  for (genvar i = 0; i < LEAVES; i++) begin : g_li
    for (genvar j = 0; j < LEAVES; j++) begin : g_lj
      logic [1:0] a2;
      logic [1:0] b2;
      logic       pp1;
      logic       pp2;
      logic       pp3;
      logic       c1;
      assign a2  = a_mag[2*i +: 2];
      assign b2  = b_mag[2*j +: 2];
      assign pp1 = a2[1] & b2[0];
      assign pp2 = a2[0] & b2[1];
      assign pp3 = a2[1] & b2[1];
      assign c1  = pp1 & pp2;
      assign d_raw[(i*LEAVES+j)*4 +: 4] = {pp3 & c1, pp3 ^ c1, pp1 ^ pp2, a2[0] & b2[0]};
    end
  end

  // Level s combines four half-width products from the previous register stage.
  for (genvar s = 1; s < STAGES; s++) begin : g_lvl
    localparam int N    = 2 << s;
    localparam int H    = N / 2;
    localparam int C    = WIDTH / N;
    localparam int CP   = 2 * C;
    localparam int PW   = 2 * N;
    localparam int OFF  = 2*WIDTH*WIDTH - ((2*WIDTH*WIDTH) >> s);
    localparam int OFFP = 2*WIDTH*WIDTH - ((2*WIDTH*WIDTH) >> (s-1));
    for (genvar i = 0; i < C; i++) begin : g_ci
      for (genvar j = 0; j < C; j++) begin : g_cj
        logic [PW-1:0] ll;
        logic [PW-1:0] lh;
        logic [PW-1:0] hl;
        logic [PW-1:0] hh;
        assign ll = {{N{1'b0}}, q_all[OFFP + ((2*i)*CP   + 2*j  )*N +: N]};
        assign lh = {{N{1'b0}}, q_all[OFFP + ((2*i)*CP   + 2*j+1)*N +: N]};
        assign hl = {{N{1'b0}}, q_all[OFFP + ((2*i+1)*CP + 2*j  )*N +: N]};
        assign hh = {{N{1'b0}}, q_all[OFFP + ((2*i+1)*CP + 2*j+1)*N +: N]};
        assign d_raw[OFF + (i*C+j)*PW +: PW] = ll + ((lh + hl) << H) + (hh << N);
      end
    end
  end

`ifdef VEDIC_MULT_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic sgn_in;
  logic sgn_last;

  assign neg_a  = in_signed & in_a[WIDTH-1];
  assign neg_b  = in_signed & in_b[WIDTH-1];
  assign a_mag  = neg_a ? -in_a : in_a;
  assign b_mag  = neg_b ? -in_b : in_b;
  assign sgn_in = neg_a ^ neg_b;

  // Sign rides alongside the data so the last stage can negate without extra latency.
  if (STAGES == 1) begin : g_sgn_direct
    assign sgn_last = sgn_in;
  end else begin : g_sgn_pipe
    logic [STAGES-2:0] sgn_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      sgn_q <= '0;
      else if (adv) sgn_q <= (sgn_q << 1) | (STAGES-1)'(sgn_in);
    end
    assign sgn_last = sgn_q[STAGES-2];
  end

  always_comb begin
    d_all = d_raw;
    if (sgn_last) d_all[OFF_LAST +: 2*WIDTH] = -d_raw[OFF_LAST +: 2*WIDTH];
  end
`else
  assign a_mag = in_a;
  assign b_mag = in_b;
  assign d_all = d_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      q_all <= '0;
    end else if (adv) begin
      vld   <= (vld << 1) | STAGES'(in_valid);
      q_all <= d_all;
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe at WIDTH 8 and 4: directed latency/stall/reset cases plus random traffic
// checked against an arithmetic product queue.
`timescale 1ns/1ps
module tb_vedic_mult_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, ir8, ov8, or8, busy8, sg8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          push4  = 0;
  int          pops4  = 0;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
`ifdef VEDIC_MULT_SIGNED_EN
    .in_signed(sg8),
`endif
    .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(busy8)
  );

  vedic_mult_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
`ifdef VEDIC_MULT_SIGNED_EN
    .in_signed(1'b0),
`endif
    .out_valid(ov4), .out_ready(or4), .out_p(p4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic [15:0]        r;
    r = 16'(a) * 16'(b);
    sa = $signed(a);
    sb = $signed(b);
`ifdef VEDIC_MULT_SIGNED_EN
    if (s) r = sa * sb;
`else
    if (s && (sa != sb)) r = r;
`endif
    return r;
  endfunction

  task automatic cyc8(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic ordy);
    logic [15:0] e;
    iv8 = v; a8 = a; b8 = b; sg8 = s; or8 = ordy;
    #1;
    if (ov8 && or8) begin
      if (q8.size() == 0) check("p8_unexpected", {31'd0, ov8}, 32'd0);
      else begin
        e = q8.pop_front();
        check("p8", {16'd0, p8}, {16'd0, e});
      end
    end
    if (v && ir8) q8.push_back(ref8(a, b, s));
    @(posedge clk); #1;
    check("busy8", {31'd0, busy8}, {31'd0, q8.size() != 0});
  endtask

  task automatic cyc4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ordy);
    logic [7:0] e;
    iv4 = v; a4 = a; b4 = b; or4 = ordy;
    #1;
    if (ov4 && or4) begin
      if (q4.size() == 0) check("p4_unexpected", {31'd0, ov4}, 32'd0);
      else begin
        e = q4.pop_front();
        pops4++;
        check("p4", {24'd0, p4}, {24'd0, e});
      end
    end
    if (v && ir4) begin
      q4.push_back(8'(a) * 8'(b));
      push4++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_one8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] e);
    logic seen;
    seen = 1'b0;
    cyc8(1'b1, a, b, s, 1'b1);
    for (int k = 0; k < 10 && !seen; k++) begin
      if (ov8) begin
        seen = 1'b1;
        check(tag, {16'd0, p8}, {16'd0, e});
      end
      cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    end
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; sg8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; or4 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov8",   {31'd0, ov8},   32'd0);
    check("rst_p8",    {16'd0, p8},    32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_rdy8",  {31'd0, ir8},   32'd1);
    check("rst_ov4",   {31'd0, ov4},   32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_rdy4",  {31'd0, ir4},   32'd1);
    rst = 1'b0;

    // 255*255 accepted at cycle 0 must appear exactly at cycle 3.
    cyc8(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
    check("lat_c1", {31'd0, ov8}, 32'd0);
    cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("lat_c2", {31'd0, ov8}, 32'd0);
    cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("lat_c3", {31'd0, ov8}, 32'd1);
    check("lat_p",  {16'd0, p8},  32'h0000FE01);
    cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

    // Three products, then the consumer stalls for five cycles.
    cyc8(1'b1, 8'd3,  8'd5,  1'b0, 1'b0);
    cyc8(1'b1, 8'd7,  8'd9,  1'b0, 1'b0);
    cyc8(1'b1, 8'd11, 8'd13, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("stall_v",   {31'd0, ov8}, 32'd1);
      check("stall_p",   {16'd0, p8},  32'd15);
      check("stall_rdy", {31'd0, ir8}, 32'd0);
      cyc8(1'b1, 8'd200, 8'd200, 1'b0, 1'b0);
    end
    repeat (4) cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("stall_drain", q8.size(), 32'd0);

    // Reset with two entries in flight.
    cyc8(1'b1, 8'd21, 8'd3, 1'b0, 1'b1);
    cyc8(1'b1, 8'd4,  8'd6, 1'b0, 1'b1);
    #2; rst = 1'b1; #1;
    check("mrst_ov",   {31'd0, ov8},   32'd0);
    check("mrst_busy", {31'd0, busy8}, 32'd0);
    check("mrst_rdy",  {31'd0, ir8},   32'd1);
    check("mrst_p",    {16'd0, p8},    32'd0);
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      check("mrst_nout", {31'd0, ov8}, 32'd0);
    end

    // Random traffic with random backpressure and bubbles.
    for (int c = 0; c < 400; c++)
      cyc8($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
           1'($urandom), $urandom_range(0, 9) < 7);
    for (int c = 0; c < 20 && q8.size() != 0; c++) cyc8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("drain8", q8.size(), 32'd0);

    // Every 4-bit pair back to back: one product per cycle, in order.
    for (int x = 0; x < 256; x++) cyc4(1'b1, 4'(x >> 4), 4'(x), 1'b1);
    repeat (2) cyc4(1'b0, 4'd0, 4'd0, 1'b1);
    check("n_push4", push4, 32'd256);
    check("n_pop4",  pops4, 32'd256);

    run_one8("u_80x80", 8'h80, 8'h80, 1'b0, 16'h4000);
`ifdef VEDIC_MULT_SIGNED_EN
    run_one8("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_one8("s_m1x1",   8'hFF, 8'h01, 1'b1, 16'hFFFF);
    run_one8("s_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vedic_mult_pipe.md
VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are powers of two from 2 to 32.
REQ-002 SHALL have derived localparam STAGES, equal to log2(WIDTH), giving the pipeline register depth.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the operands are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have port in_a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port in_b, input, WIDTH bits: multiplier.
REQ-009 SHALL have port in_signed, input, 1 bit: the operands are two's complement (present only per REQ-024).
REQ-010 SHALL have port out_valid, output, 1 bit: out_p holds a valid product.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-012 SHALL have port out_p, output, 2*WIDTH bits: the product.
REQ-013 SHALL have port busy, output, 1 bit: at least one pipeline stage holds a valid entry.

Function
REQ-014 SHALL compute out_p = in_a * in_b exactly, in 2*WIDTH bits, with no truncation or overflow.
REQ-015 SHALL build products by recursive Vedic decomposition:
- Leaves are 2x2 gate-level multipliers: AND partial products, then half-adders.
- Each level combines four half-width products: p = LL + ((LH + HL) << W/2) + (HH << W).
REQ-016 SHALL register the pipeline as follows:
- Stage 1 registers all leaf products.
- Stage k (k = 2..STAGES) registers the level-k combinations.
- A valid bit travels with each stage.
REQ-017 SHALL define the advance signal adv = out_ready OR NOT out_valid; when adv = 1, all stages shift by one.
REQ-018 SHALL drive in_ready = adv; an operand pair is captured only when in_valid AND in_ready.
REQ-019 SHALL give a latency of exactly STAGES cycles from acceptance to out_valid when there is no stall.
REQ-019 (cont.) SHALL sustain a throughput of one product per cycle.
REQ-020 SHALL hold the pipeline state while out_valid = 1 AND out_ready = 0:
- out_p stays stable.
- All stages freeze.
- in_ready = 0.
- No entry is lost or reordered.
REQ-021 SHALL propagate bubbles (in_valid = 0 at an accepted cycle) as invalid entries; bubbles are not compressed.
REQ-022 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-023 SHALL behave as follows while rst = 1, including mid-operation:
- Immediately clear all valid bits and all data registers to 0.
- out_valid = 0 and out_p = 0.
- busy = 0.
- in_ready = 1.
- No pre-reset entry ever emerges after reset is released.

Configuration
REQ-024 SHALL implement macro VEDIC_MULT_SIGNED_EN as follows:
- When defined:
  - The in_signed port exists and is captured with the operands.
  - With in_signed = 1, the magnitudes of the operands are multiplied.
  - The sign (a_msb XOR b_msb) is pipelined alongside the data.
  - The final stage negates the result, giving a signed 2*WIDTH-bit out_p.
  - Latency is unchanged.
- When undefined: the in_signed port is absent and all operation is unsigned.

Verification
REQ-025 SHALL cover, with WIDTH = 8: a = 255, b = 255 accepted at cycle 0 -> out_valid at cycle 3 with out_p = 0xFE01.
REQ-026 SHALL cover, with WIDTH = 4: all 256 pairs streamed back-to-back with out_ready = 1 -> one product per cycle, in order, each equal to a*b.
REQ-027 SHALL cover, with WIDTH = 8: issue 3,5 / 7,9 / 11,13, then hold out_ready = 0 for 5 cycles -> out_p is held at 15, in_ready = 0, then 15, 63, 143 emerge in order.
REQ-028 SHALL cover: rst pulsed while 2 entries are in flight -> out_valid = 0 and busy = 0 at once, and no products appear afterwards.
REQ-029 SHALL cover, with macro defined and WIDTH = 8:
- -128 * -128 gives out_p = 0x4000.
- -1 * 1 gives out_p = 0xFFFF.
- in_signed = 0 with 0x80 * 0x80 gives out_p = 0x4000.
